// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared constants and types for the PS/2 keyboard receive path.
//   PS2_EXT / PS2_REL / PS2_PAUSE : prefix bytes the byte layer reacts to
//   PAUSE_SKIP                    : bytes swallowed after the Pause prefix
//   FRAME_BITS / DATA_BITS        : frame geometry (start, data, parity, stop)
//   frame_state_t                 : states of the frame receiver
//   odd_parity_ok()               : true when data plus parity bit is odd
package ps2_pkg;

   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] PS2_REL   = 8'hF0;
   localparam logic [7:0] PS2_PAUSE = 8'hE1;
   localparam int         PAUSE_SKIP = 7;
   localparam int         FRAME_BITS = 11;
   localparam int         DATA_BITS  = FRAME_BITS - 3;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } frame_state_t;

   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx
// Turns raw, asynchronous PS/2 clock/data pins into validated bytes.
// Ports:
//   clk         in   system clock
//   resetN      in   synchronous active-low reset
//   ps2_clk     in   raw PS/2 clock pin (asynchronous)
//   ps2_data    in   raw PS/2 data pin (asynchronous)
//   rx_byte     out  last received data byte, valid while byte_valid is high
//   byte_valid  out  one-cycle pulse: a frame passed start/parity/stop checks
//   frame_error out  one-cycle pulse: bad parity/stop bit or mid-frame timeout
// Both pins are resynchronised, the clock is deglitched, and a falling edge
// of the filtered clock is the point at which one frame bit is taken.
module ps2_frame_rx
   import ps2_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEGLITCH_CYCLES = 8,
   parameter int TIMEOUT_CYCLES  = 25000
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_error
);

   localparam int DG_W = (DEGLITCH_CYCLES > 1) ? $clog2(DEGLITCH_CYCLES) : 1;
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   clk_s;
   logic                   data_s;

   logic                   clk_filt;
   logic [DG_W-1:0]        dg_cnt;
   logic                   dg_done;
   logic                   sample;

   frame_state_t           state;
   frame_state_t           state_next;
   logic [2:0]             bit_cnt;
   logic [2:0]             bit_next;
   logic [7:0]             shift_reg;
   logic [7:0]             shift_next;
   logic                   par_bit;
   logic                   par_next;
   logic [TO_W-1:0]        to_cnt;
   logic [TO_W-1:0]        to_next;
   logic                   valid_next;
   logic                   err_next;

   // Synchroniser chains. They reset to 1 because an idle PS/2 bus is high,
   // so leaving reset never looks like a clock edge.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         clk_sync  <= '1;
         data_sync <= '1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
         data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      end
   end

   assign clk_s  = clk_sync[SYNC_STAGES-1];
   assign data_s = data_sync[SYNC_STAGES-1];

   // Deglitch filter: the filtered level only follows the synced clock after
   // DEGLITCH_CYCLES consecutive samples that disagree with it. Any sample
   // that agrees again restarts the count, so short pulses vanish.
   assign dg_done = (dg_cnt == DG_W'(DEGLITCH_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!resetN) begin
         clk_filt <= 1'b1;
         dg_cnt   <= '0;
      end else if (clk_s == clk_filt) begin
         dg_cnt <= '0;
      end else if (dg_done) begin
         clk_filt <= clk_s;
         dg_cnt   <= '0;
      end else begin
         dg_cnt <= dg_cnt + 1'b1;
      end
   end

   // A bit is taken in the cycle the filtered clock is about to fall; the
   // synced data is already stable there because the device sets data well
   // before it drops the clock.
   assign sample = clk_filt & ~clk_s & dg_done;

   // Frame FSM register, including the registered result pulses.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         shift_reg   <= '0;
         par_bit     <= 1'b0;
         to_cnt      <= '0;
         byte_valid  <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         state       <= state_next;
         bit_cnt     <= bit_next;
         shift_reg   <= shift_next;
         par_bit     <= par_next;
         to_cnt      <= to_next;
         byte_valid  <= valid_next;
         frame_error <= err_next;
      end
   end

   // Frame FSM next state. The timeout counter measures clocks since the
   // last sample while a frame is in progress; reaching the limit abandons
   // the frame, which overrides whatever the state machine chose.
   always_comb begin
      state_next = state;
      bit_next   = bit_cnt;
      shift_next = shift_reg;
      par_next   = par_bit;
      to_next    = '0;
      valid_next = 1'b0;
      err_next   = 1'b0;

      if (state != IDLE && !sample) begin
         to_next = to_cnt + 1'b1;
      end

      case (state)
         IDLE: begin
            if (sample && !data_s) begin
               state_next = DATA;
               bit_next   = '0;
            end
         end
         DATA: begin
            if (sample) begin
               shift_next = {data_s, shift_reg[7:1]};
               if (bit_cnt == 3'(DATA_BITS - 1)) begin
                  state_next = PARITY;
               end else begin
                  bit_next = bit_cnt + 1'b1;
               end
            end
         end
         PARITY: begin
            if (sample) begin
               par_next   = data_s;
               state_next = STOP;
            end
         end
         STOP: begin
            if (sample) begin
               state_next = IDLE;
               if (data_s && odd_parity_ok(shift_reg, par_bit)) begin
                  valid_next = 1'b1;
               end else begin
                  err_next = 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      if (state != IDLE && !sample && to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
         state_next = IDLE;
         err_next   = 1'b1;
         to_next    = '0;
      end
   end

   assign rx_byte = shift_reg;

endmodule

// File: rtl/ps2_keycode_decoder.sv
// ps2_keycode_decoder
// Keyboard front end for the game: receives PS/2 frames and folds the E0
// (extended), F0 (release) and E1 (Pause) prefixes into one key event.
// Ports:
//   clk         in   system clock
//   resetN      in   synchronous active-low reset
//   ps2_clk     in   raw PS/2 clock pin (asynchronous)
//   ps2_data    in   raw PS/2 data pin (asynchronous)
//   keyCode     out  {extended, scan byte} of the last key event, held
//   make        out  one-cycle pulse: key pressed or typematic repeat
//   brake       out  one-cycle pulse: key released
//   frame_error out  one-cycle pulse: malformed frame or mid-frame timeout
module ps2_keycode_decoder
   import ps2_pkg::*;
#(
   parameter int KEYCODE_WIDTH   = 9,
   parameter int SYNC_STAGES     = 2,
   parameter int DEGLITCH_CYCLES = 8,
   parameter int TIMEOUT_CYCLES  = 25000
) (
   input  logic                     clk,
   input  logic                     resetN,
   input  logic                     ps2_clk,
   input  logic                     ps2_data,
   output logic [KEYCODE_WIDTH-1:0] keyCode,
   output logic                     make,
   output logic                     brake,
   output logic                     frame_error
);

   localparam int SKIP_W = $clog2(PAUSE_SKIP + 1);

   logic [7:0]        rx_byte;
   logic              rx_valid;
   logic              rx_err;
   logic              ext;
   logic              rel;
   logic [SKIP_W-1:0] skip_cnt;

   ps2_frame_rx #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEGLITCH_CYCLES (DEGLITCH_CYCLES),
      .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
   ) u_frame_rx (
      .clk         (clk),
      .resetN      (resetN),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .rx_byte     (rx_byte),
      .byte_valid  (rx_valid),
      .frame_error (rx_err)
   );

   // Byte layer. Prefixes only set flags; the first ordinary byte consumes
   // them and produces exactly one make or brake pulse. The Pause key sends
   // E1 followed by seven bytes that look like ordinary codes, so they are
   // counted off and dropped. A broken frame may have swallowed a prefix,
   // so pending prefixes are forgotten rather than applied to a later key.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         keyCode     <= '0;
         make        <= 1'b0;
         brake       <= 1'b0;
         frame_error <= 1'b0;
         ext         <= 1'b0;
         rel         <= 1'b0;
         skip_cnt    <= '0;
      end else begin
         make        <= 1'b0;
         brake       <= 1'b0;
         frame_error <= rx_err;
         if (rx_err) begin
            ext <= 1'b0;
            rel <= 1'b0;
         end else if (rx_valid) begin
            if (skip_cnt != '0) begin
               skip_cnt <= skip_cnt - 1'b1;
            end else begin
               case (rx_byte)
                  PS2_EXT: begin
                     ext <= 1'b1;
                  end
                  PS2_REL: begin
                     rel <= 1'b1;
                  end
                  PS2_PAUSE: begin
                     skip_cnt <= SKIP_W'(PAUSE_SKIP);
                     ext      <= 1'b0;
                     rel      <= 1'b0;
                  end
                  default: begin
                     keyCode <= KEYCODE_WIDTH'({ext, rx_byte});
                     if (rel) begin
                        brake <= 1'b1;
                     end else begin
                        make <= 1'b1;
                     end
                     ext <= 1'b0;
                     rel <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// tb_ps2_keycode_decoder
// Drives PS/2 frames into ps2_keycode_decoder and checks every make, brake
// and frame_error pulse against a queue of expected events.
module tb_ps2_keycode_decoder;

   localparam int HALF    = 20;
   localparam int TIMEOUT = 1000;
   localparam int LAT     = 11;
   localparam int NVEC    = 15;

   localparam logic [1:0] K_NONE  = 2'd0;
   localparam logic [1:0] K_MAKE  = 2'd1;
   localparam logic [1:0] K_BRAKE = 2'd2;
   localparam logic [1:0] K_ERR   = 2'd3;

   typedef struct packed {
      logic [7:0] data;
      logic       bad_par;
      logic [1:0] kind;
      logic [8:0] code;
   } vec_t;

   typedef struct packed {
      logic [1:0] kind;
      logic [8:0] code;
   } exp_t;

   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [8:0] keyCode;
   logic       make;
   logic       brake;
   logic       frame_error;

   int   tests = 0;
   int   failures = 0;
   exp_t exp_q[$];
   vec_t vecs[NVEC];

   always #5 clk = ~clk;

   ps2_keycode_decoder #(
      .KEYCODE_WIDTH   (9),
      .SYNC_STAGES     (2),
      .DEGLITCH_CYCLES (8),
      .TIMEOUT_CYCLES  (TIMEOUT)
   ) dut (
      .clk         (clk),
      .resetN      (resetN),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .keyCode     (keyCode),
      .make        (make),
      .brake       (brake),
      .frame_error (frame_error)
   );

   function automatic logic [10:0] frameBits(input logic [7:0] d, input logic bad);
      return {1'b1, (~^d) ^ bad, d, 1'b0};
   endfunction

   function automatic vec_t mk(input logic [7:0] d, input logic bad, input logic [1:0] k,
                               input logic [8:0] c);
      vec_t v;
      v.data = d;
      v.bad_par = bad;
      v.kind = k;
      v.code = c;
      return v;
   endfunction

   task automatic checkOutput(input string name, input int got, input int want);
      tests++;
      if (got !== want) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
      end
   endtask

   // Sends the first nbits of a frame, LSB first. When measure is set, the
   // clocks from the last falling edge to the first output pulse are counted.
   task automatic applyStimulus(input logic [10:0] bits, input int nbits, input bit measure,
                                output int lat);
      lat = -1;
      for (int i = 0; i < nbits; i++) begin
         ps2_data = bits[i];
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b0;
         if (measure && i == nbits - 1) begin
            for (int c = 1; c <= HALF; c++) begin
               @(posedge clk);
               #1;
               if (lat < 0 && (make || brake || frame_error)) lat = c;
            end
            @(negedge clk);
         end else begin
            repeat (HALF) @(negedge clk);
         end
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   task automatic sendByte(input logic [7:0] d);
      int lat;
      applyStimulus(frameBits(d, 1'b0), 11, 1'b0, lat);
      repeat (2 * HALF) @(negedge clk);
   endtask

   task automatic checkEmpty(input string name);
      checkOutput({name, " pending events"}, exp_q.size(), 0);
   endtask

   // Scoreboard monitor: every pulse must match the oldest expected event.
   always @(negedge clk) begin
      logic [1:0] got_kind;
      exp_t       e;
      if (resetN && (make || brake || frame_error)) begin
         tests++;
         got_kind = make ? K_MAKE : (brake ? K_BRAKE : K_ERR);
         if ((int'(make) + int'(brake) + int'(frame_error)) > 1) begin
            failures++;
            $display("[TB] FAIL pulse overlap: make=%0b brake=%0b err=%0b", make, brake,
                     frame_error);
         end else if (exp_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected pulse: kind %0d code 0x%03h, expected none",
                     got_kind, keyCode);
         end else begin
            e = exp_q.pop_front();
            if (got_kind !== e.kind || keyCode !== e.code) begin
               failures++;
               $display("[TB] FAIL pulse: kind %0d code 0x%03h, expected kind %0d code 0x%03h",
                        got_kind, keyCode, e.kind, e.code);
            end
         end
      end
   end

   initial begin
      #900000;
      $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat;
      logic [7:0] pause_seq[8];

      vecs[0]  = mk(8'h75, 1'b0, K_MAKE,  9'h075);
      vecs[1]  = mk(8'hE0, 1'b0, K_NONE,  9'h000);
      vecs[2]  = mk(8'h75, 1'b0, K_MAKE,  9'h175);
      vecs[3]  = mk(8'hE0, 1'b0, K_NONE,  9'h000);
      vecs[4]  = mk(8'hF0, 1'b0, K_NONE,  9'h000);
      vecs[5]  = mk(8'h74, 1'b0, K_BRAKE, 9'h174);
      vecs[6]  = mk(8'hF0, 1'b0, K_NONE,  9'h000);
      vecs[7]  = mk(8'h6B, 1'b0, K_BRAKE, 9'h06B);
      vecs[8]  = mk(8'h70, 1'b0, K_MAKE,  9'h070);
      vecs[9]  = mk(8'h74, 1'b1, K_ERR,   9'h070);
      vecs[10] = mk(8'h73, 1'b0, K_MAKE,  9'h073);
      vecs[11] = mk(8'h73, 1'b0, K_MAKE,  9'h073);
      vecs[12] = mk(8'hE0, 1'b0, K_NONE,  9'h000);
      vecs[13] = mk(8'h11, 1'b1, K_ERR,   9'h073);
      vecs[14] = mk(8'h75, 1'b0, K_MAKE,  9'h075);

      pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("reset keyCode", keyCode, 0);
      checkOutput("reset make", make, 0);
      checkOutput("reset brake", brake, 0);
      checkOutput("reset frame_error", frame_error, 0);
      resetN = 1'b1;
      repeat (5) @(negedge clk);

      // Table-driven frames with pulse latency
      for (int i = 0; i < NVEC; i++) begin
         if (vecs[i].kind != K_NONE) exp_q.push_back({vecs[i].kind, vecs[i].code});
         applyStimulus(frameBits(vecs[i].data, vecs[i].bad_par), 11, vecs[i].kind != K_NONE, lat);
         if (vecs[i].kind != K_NONE) checkOutput($sformatf("latency row %0d", i), lat, LAT);
         repeat (2 * HALF) @(negedge clk);
         checkEmpty($sformatf("row %0d", i));
      end
      checkOutput("keyCode held", keyCode, 9'h075);

      // Mid-frame timeout
      exp_q.push_back({K_ERR, 9'h075});
      applyStimulus(frameBits(8'h5A, 1'b0), 5, 1'b0, lat);
      repeat (TIMEOUT + 2 * HALF) @(negedge clk);
      checkEmpty("timeout");

      // Short low glitch with data low must not start a frame
      ps2_data = 1'b0;
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      repeat (TIMEOUT + 2 * HALF) @(negedge clk);
      checkEmpty("glitch");

      // Pause sequence produces nothing, next key does
      foreach (pause_seq[i]) sendByte(pause_seq[i]);
      checkEmpty("pause");
      checkOutput("pause keyCode held", keyCode, 9'h075);
      exp_q.push_back({K_MAKE, 9'h075});
      sendByte(8'h75);
      checkEmpty("after pause");

      // Reset in the middle of a frame
      applyStimulus(frameBits(8'h33, 1'b0), 5, 1'b0, lat);
      resetN = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("midframe reset keyCode", keyCode, 0);
      checkOutput("midframe reset make", make, 0);
      checkOutput("midframe reset brake", brake, 0);
      checkOutput("midframe reset frame_error", frame_error, 0);
      @(negedge clk);
      resetN = 1'b1;
      repeat (5) @(negedge clk);
      exp_q.push_back({K_MAKE, 9'h06B});
      sendByte(8'h6B);
      checkEmpty("after reset");
      checkOutput("final keyCode", keyCode, 9'h06B);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
